// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch unit. Issues fetch requests for pc_i over a
//               request/grant, in-order response interface, buffers returned
//               words with their addresses in a small in-order queue and
//               presents them to decode with valid/ready. A taken jump
//               (PCSel_i) flushes wrong-path entries and discards responses
//               still in flight.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN adds the
//               fetch_misalign_o output and blocks misaligned fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              PCSel_i,
  output logic              pc_stopFlag_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_misalign_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;   // reserved slots
  logic [CNT_W-1:0]  pend_q,  pend_d;    // reserved, awaiting response
  logic [CNT_W-1:0]  stale_q, stale_d;   // wrong-path responses to drop
  logic [PTR_W-1:0]  head_q,  head_d;
  logic [PTR_W-1:0]  fill_q,  fill_d;
  logic [PTR_W-1:0]  tail_q,  tail_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;

  logic              is_run;
  logic              misalign;
  logic              issue;
  logic              fill;
  logic              pop;
  logic [CNT_W-1:0]  sif_src;
  logic [CNT_W-1:0]  sif;

  assign imem_addr_o  = pc_i;
  assign inst_valid_o = filled_q[head_q];
  assign inst_o       = data_q[head_q];
  assign inst_addr_o  = addr_q[head_q];

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misalign_o = misalign;
`endif

  // Request, PC stall and the per-cycle issue/fill/pop events.
  always_comb begin
    is_run   = (state_q == ST_RUN);
    misalign = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign = is_run & ~PCSel_i & (pc_i[1:0] != 2'b00);
`endif
    // Registered count only: a same-cycle pop does not free a slot for issue.
    imem_req_o    = rst_i & is_run & ~PCSel_i & ~misalign &
                    (count_q < CNT_W'(DEPTH));
    issue         = imem_req_o & imem_gnt_i;
    // The PC moves only on a granted request or a jump.
    pc_stopFlag_o = ~rst_i | (~issue & ~PCSel_i);
    // A response with nothing pending is a protocol error and is ignored.
    fill          = is_run & imem_rvalid_i & (pend_q != '0);
    pop           = inst_valid_o & inst_ready_i & ~PCSel_i;
    // Responses still owed to wrong-path requests after a jump this cycle.
    sif_src       = is_run ? pend_q : stale_q;
    sif           = (imem_rvalid_i && (sif_src != '0)) ? sif_src - CNT_W'(1) : sif_src;
  end

  // Next-state for FSM, counters, pointers and queue entries.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_d   = pend_q;
    stale_d  = stale_q;
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    addr_d   = addr_q;
    data_d   = data_q;
    filled_d = filled_q;

    if (PCSel_i) begin
      // Jump wins over any pop, fill or issue in the same cycle.
      count_d  = '0;
      pend_d   = '0;
      head_d   = '0;
      fill_d   = '0;
      tail_d   = '0;
      filled_d = '0;
      stale_d  = sif;
      state_d  = (sif != '0) ? ST_FLUSH : ST_RUN;
    end else if (!is_run) begin
      if (imem_rvalid_i && (stale_q != '0)) begin
        stale_d = stale_q - CNT_W'(1);
        if (stale_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
    end else begin
      // Popped, issued and filled slots are always distinct, so order is free.
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      if (issue) begin
        addr_d[tail_q] = pc_i;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (fill) begin
        data_d[fill_q]   = imem_rdata_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(issue) - CNT_W'(fill);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      count_q  <= '0;
      pend_q   <= '0;
      stale_q  <= '0;
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      filled_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      stale_q  <= stale_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      filled_q <= filled_d;
    end
  end

endmodule
`default_nettype wire
